// File: rtl/clock_gate_enable_ctrl_pkg.sv
// rtl/clock_gate_enable_ctrl_pkg.sv - shared state encoding and width defaults for the clock-enable controller
package clock_gate_enable_ctrl_pkg;

  localparam int DIV_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/clock_gate_enable_ctrl_phase_counter.sv
// rtl/clock_gate_enable_ctrl_phase_counter.sv - host:target ratio phase counter producing the fire-eligible tick
module clock_ratio_phase_counter
  import clock_gate_enable_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic                 i_load,
  input  logic                 i_fire,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH-1:0] r_phase;
  logic [DIV_WIDTH-1:0] w_div_eff;

  assign w_div_eff = (i_divisor == '0) ? DIV_WIDTH'(1) : i_divisor;
  // r_div is never zero, so the subtraction cannot wrap
  assign o_tick    = (r_phase == (r_div - DIV_WIDTH'(1)));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div   <= DIV_WIDTH'(1);
      r_phase <= '0;
    end else if (i_load) begin
      r_div   <= w_div_eff;
      r_phase <= '0;
    end else if (i_run) begin
      if (i_fire) begin
        r_div   <= w_div_eff;
        r_phase <= '0;
      end else if (!o_tick) begin
        r_phase <= r_phase + DIV_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/clock_gate_enable_ctrl.sv
// rtl/clock_gate_enable_ctrl.sv - registered clock-enable generator for a token-driven gated target clock
module clock_gate_enable_ctrl
  import clock_gate_enable_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run_en,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ce,
  input  logic                 halt_req,
  output logic                 halt_ack,
  input  logic                 limit_en,
  input  logic [CNT_WIDTH-1:0] cycle_limit,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 done
);

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_load;
  logic                 w_tick;
  logic                 w_fire;
  logic                 w_limit_hit;
  logic                 w_stop;
  logic                 r_ce;
  logic                 r_out_valid;
  logic [CNT_WIDTH-1:0] r_count;

  assign w_limit_hit = limit_en && (r_count >= cycle_limit);
  assign w_stop      = halt_req || !run_en || w_limit_hit;
  assign w_fire      = (r_state == ST_RUN) && w_tick && in_valid &&
                       (!r_out_valid || out_ready) && !w_stop;

  clock_ratio_phase_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_phase (
    .clock     (clock),
    .reset     (reset),
    .i_run     (r_state == ST_RUN),
    .i_load    (w_load),
    .i_fire    (w_fire),
    .i_divisor (divisor),
    .o_tick    (w_tick)
  );

  // w_load marks every entry into RUN so the ratio is resampled and phase restarts
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (halt_req) begin
          w_state_next = ST_HALTED;
        end else if (run_en) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_stop) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!r_out_valid) w_state_next = ST_HALTED;
      end
      ST_HALTED: begin
        if (!halt_req && run_en && !w_limit_hit) begin
          w_state_next = ST_RUN;
          w_load       = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ce        <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_next;
      r_ce    <= w_fire;
      if (w_fire) begin
        r_out_valid <= 1'b1;
      end else if (out_ready && r_out_valid) begin
        r_out_valid <= 1'b0;
      end
      if (w_fire && (r_count != '1)) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end
    end
  end

  assign in_ready    = w_fire;
  assign out_valid   = r_out_valid;
  assign ce          = r_ce;
  assign cycle_count = r_count;
  assign halt_ack    = (r_state == ST_HALTED);
  assign done        = (r_state == ST_HALTED) && w_limit_hit;

endmodule
